// File: rtl/regbank_pkg.sv
// Shared definitions for the register-bank command sequencer.
//   ADDR_W      : bank address width (4 entries)
//   OP_*        : 3-bit command opcodes
//   state_e     : sequencer state encoding
package regbank_pkg;

    localparam int ADDR_W = 2;

    localparam logic [2:0] OP_LDI = 3'd0;
    localparam logic [2:0] OP_MOV = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_RD  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_WB    = 2'd3
    } state_e;

endpackage

// File: rtl/regbank_seq_if.sv
// Bundle of the sequencer's command, bank and result signals.
//   cmd_* : valid/ready command channel (initiator -> sequencer)
//   bk_*  : register bank access (sequencer drives addresses/data/we,
//           bank returns combinational read data)
//   res_* : one-cycle result strobe with value and flags
// modport slave  : the sequencer side
// modport master : the environment side (command source + bank)
interface regbank_seq_if #(
    parameter int Size = 8
);
    import regbank_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_dst;
    logic [ADDR_W-1:0] cmd_src1;
    logic [ADDR_W-1:0] cmd_src2;
    logic [Size-1:0]   cmd_imm;

    logic [ADDR_W-1:0] bk_a1;
    logic [ADDR_W-1:0] bk_a2;
    logic [Size-1:0]   bk_wd;
    logic              bk_we;
    logic [Size-1:0]   bk_rd1;
    logic [Size-1:0]   bk_rd2;

    logic              res_valid;
    logic [Size-1:0]   res_data;
    logic              res_zero;
    logic              res_carry;

    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_src1, cmd_src2, cmd_imm,
        input  bk_rd1, bk_rd2,
        output cmd_ready, bk_a1, bk_a2, bk_wd, bk_we,
        output res_valid, res_data, res_zero, res_carry
    );

    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_src1, cmd_src2, cmd_imm,
        output bk_rd1, bk_rd2,
        input  cmd_ready, bk_a1, bk_a2, bk_wd, bk_we,
        input  res_valid, res_data, res_zero, res_carry
    );

endinterface

// File: rtl/seq_alu.sv
// Combinational ALU for the sequencer.
//   op     : opcode (regbank_pkg OP_*)
//   a, b   : captured source operands
//   imm    : immediate for LDI
//   result : Size-bit result
//   zero   : result == 0
//   carry  : bit Size of the (Size+1)-bit sum/difference; 0 otherwise
module seq_alu
    import regbank_pkg::*;
#(
    parameter int Size = 8
) (
    input  logic [2:0]      op,
    input  logic [Size-1:0] a,
    input  logic [Size-1:0] b,
    input  logic [Size-1:0] imm,
    output logic [Size-1:0] result,
    output logic            zero,
    output logic            carry
);

    logic [Size:0] sum;
    logic [Size:0] diff;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        // Top bit of the zero-extended difference is the borrow.
        diff   = {1'b0, a} - {1'b0, b};
        result = a;
        carry  = 1'b0;
        case (op)
            OP_LDI: result = imm;
            OP_MOV: result = a;
            OP_ADD: begin
                result = sum[Size-1:0];
                carry  = sum[Size];
            end
            OP_SUB: begin
                result = diff[Size-1:0];
                carry  = diff[Size];
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_RD:  result = a;
            default: result = a;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/regbank_seq.sv
// Command sequencer in front of a 4-entry register bank.
//   clk : single clock, rising edge
//   rst : synchronous, active-high reset
//   bus : regbank_seq_if.slave (command in, bank access out, result strobe out)
// Every output is a flop; no combinational path from cmd_* to bk_*.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | cmd_ready=1, waiting for cmd_valid
// S_FETCH | bank addressed with src1/src2, operands captured at exit
// S_EXEC  | ALU result/flags and write-back drive registered at exit
// S_WB    | bk_we (unless RD) and res_valid high for one cycle
module regbank_seq
    import regbank_pkg::*;
#(
    parameter int Size = 8,
    parameter int nreg = 4
) (
    input  logic          clk,
    input  logic          rst,
    regbank_seq_if.slave  bus
);

    localparam int AW = $clog2(nreg);

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [AW-1:0]     dst_q, dst_d;
    logic [Size-1:0]   imm_q, imm_d;
    logic [Size-1:0]   opa_q, opa_d;
    logic [Size-1:0]   opb_q, opb_d;
    logic [Size-1:0]   result_q, result_d;
    logic              zero_q, zero_d;
    logic              carry_q, carry_d;
    logic [ADDR_W-1:0] bk_a1_q, bk_a1_d;
    logic [ADDR_W-1:0] bk_a2_q, bk_a2_d;
    logic [Size-1:0]   bk_wd_q, bk_wd_d;
    logic              bk_we_q, bk_we_d;
    logic              res_valid_q, res_valid_d;
    logic              cmd_ready_q, cmd_ready_d;

    logic [Size-1:0]   alu_result;
    logic              alu_zero;
    logic              alu_carry;

    seq_alu #(.Size(Size)) u_alu (
        .op     (op_q),
        .a      (opa_q),
        .b      (opb_q),
        .imm    (imm_q),
        .result (alu_result),
        .zero   (alu_zero),
        .carry  (alu_carry)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        dst_d       = dst_q;
        imm_d       = imm_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        result_d    = result_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        bk_a1_d     = bk_a1_q;
        bk_a2_d     = bk_a2_q;
        bk_wd_d     = bk_wd_q;
        bk_we_d     = 1'b0;
        res_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    op_d    = bus.cmd_op;
                    dst_d   = bus.cmd_dst;
                    imm_d   = bus.cmd_imm;
                    // Source addresses go straight to the bank flops so
                    // read data is valid throughout FETCH.
                    bk_a1_d = bus.cmd_src1;
                    bk_a2_d = bus.cmd_src2;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                opa_d   = bus.bk_rd1;
                opb_d   = bus.bk_rd2;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                result_d    = alu_result;
                zero_d      = alu_zero;
                carry_d     = alu_carry;
                bk_a1_d     = dst_q;
                bk_wd_d     = alu_result;
                bk_we_d     = (op_q != OP_RD);
                res_valid_d = 1'b1;
                state_d     = S_WB;
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        cmd_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            dst_q       <= '0;
            imm_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            bk_a1_q     <= '0;
            bk_a2_q     <= '0;
            bk_wd_q     <= '0;
            bk_we_q     <= 1'b0;
            res_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            dst_q       <= dst_d;
            imm_q       <= imm_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            bk_a1_q     <= bk_a1_d;
            bk_a2_q     <= bk_a2_d;
            bk_wd_q     <= bk_wd_d;
            bk_we_q     <= bk_we_d;
            res_valid_q <= res_valid_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.bk_a1     = bk_a1_q;
    assign bus.bk_a2     = bk_a2_q;
    assign bus.bk_wd     = bk_wd_q;
    assign bus.bk_we     = bk_we_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = result_q;
    assign bus.res_zero  = zero_q;
    assign bus.res_carry = carry_q;

endmodule

// File: tb/tb_regbank_seq.sv
// Self-checking bench for regbank_seq with a 4 x 8-bit register bank.
module tb_regbank_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regbank_seq_if #(.Size(8)) bus ();

    regbank_seq #(.Size(8), .nreg(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Register bank: write on rising edge, combinational reads.
    logic [7:0] bank [4] = '{default: 8'h00};
    always @(posedge clk) if (bus.bk_we) bank[bus.bk_a1] <= bus.bk_wd;
    assign bus.bk_rd1 = bank[bus.bk_a1];
    assign bus.bk_rd2 = bank[bus.bk_a2];

    // Reference register contents.
    logic [7:0] mdl [4] = '{default: 8'h00};

    // Returns {zero, carry, result} from plain integer arithmetic.
    function automatic logic [9:0] ref_op(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [7:0] imm);
        int r;
        logic c;
        c = 1'b0;
        case (op)
            3'd0: r = int'(imm);
            3'd1: r = int'(a);
            3'd2: begin r = int'(a) + int'(b); c = (r > 255); end
            3'd3: begin c = (int'(a) < int'(b)); r = int'(a) - int'(b); if (r < 0) r += 256; end
            3'd4: r = int'(a & b);
            3'd5: r = int'(a | b);
            3'd6: r = int'(a ^ b);
            default: r = int'(a);
        endcase
        r = r % 256;
        return {(r == 0), c, r[7:0]};
    endfunction

    task automatic drive_cmd(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] s1,
                             input logic [1:0] s2, input logic [7:0] imm);
        bus.cmd_op = op; bus.cmd_dst = dst; bus.cmd_src1 = s1; bus.cmd_src2 = s2; bus.cmd_imm = imm;
    endtask

    task automatic scramble_cmd();
        drive_cmd(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom));
    endtask

    // Issue one command and check every cycle of its execution.
    task automatic run_cmd(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] s1,
                           input logic [1:0] s2, input logic [7:0] imm);
        logic [9:0] exp;
        int         w;
        @(negedge clk);
        drive_cmd(op, dst, s1, s2, imm);
        bus.cmd_valid = 1'b1;
        w = 0;
        while (!bus.cmd_ready && w < 20) begin @(negedge clk); w++; end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL accept_timeout: cmd_ready=%b required 1", bus.cmd_ready);
            bus.cmd_valid = 1'b0;
            return;
        end
        exp = ref_op(op, mdl[s1], mdl[s2], imm);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        scramble_cmd();
        // FETCH
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL fetch_ready: got %b required 0", bus.cmd_ready); end
        checks++; if (bus.bk_we !== 1'b0) begin errors++; $display("FAIL fetch_we: got %b required 0", bus.bk_we); end
        checks++; if (bus.bk_a1 !== s1) begin errors++; $display("FAIL fetch_a1: got %0d required %0d", bus.bk_a1, s1); end
        checks++; if (bus.bk_a2 !== s2) begin errors++; $display("FAIL fetch_a2: got %0d required %0d", bus.bk_a2, s2); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL fetch_res_valid: got %b required 0", bus.res_valid); end
        // EXEC
        @(negedge clk);
        checks++; if (bus.bk_we !== 1'b0) begin errors++; $display("FAIL exec_we: got %b required 0", bus.bk_we); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL exec_res_valid: got %b required 0", bus.res_valid); end
        // WB
        @(negedge clk);
        checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL wb_res_valid: got %b required 1", bus.res_valid); end
        checks++; if (bus.res_data !== exp[7:0]) begin errors++; $display("FAIL wb_res_data op%0d: got %h required %h", op, bus.res_data, exp[7:0]); end
        checks++; if (bus.res_carry !== exp[8]) begin errors++; $display("FAIL wb_res_carry op%0d: got %b required %b", op, bus.res_carry, exp[8]); end
        checks++; if (bus.res_zero !== exp[9]) begin errors++; $display("FAIL wb_res_zero op%0d: got %b required %b", op, bus.res_zero, exp[9]); end
        checks++; if (bus.bk_we !== (op != 3'd7)) begin errors++; $display("FAIL wb_we op%0d: got %b required %b", op, bus.bk_we, (op != 3'd7)); end
        checks++; if (bus.bk_a1 !== dst) begin errors++; $display("FAIL wb_a1: got %0d required %0d", bus.bk_a1, dst); end
        if (op != 3'd7) begin
            checks++; if (bus.bk_wd !== exp[7:0]) begin errors++; $display("FAIL wb_wd: got %h required %h", bus.bk_wd, exp[7:0]); end
            mdl[dst] = exp[7:0];
        end
        // Back in IDLE
        @(negedge clk);
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL post_res_valid: got %b required 0", bus.res_valid); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL post_ready: got %b required 1", bus.cmd_ready); end
        checks++; if (bank[dst] !== mdl[dst]) begin errors++; $display("FAIL post_bank r%0d: got %h required %h", dst, bank[dst], mdl[dst]); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cmd_valid = 1'b1;
        scramble_cmd();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.bk_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b required 0", bus.bk_we); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid: got %b required 0", bus.res_valid); end
        checks++; if (bus.res_data !== 8'h00) begin errors++; $display("FAIL rst_res_data: got %h required 00", bus.res_data); end
        checks++; if ({bus.res_zero, bus.res_carry} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b required 00", {bus.res_zero, bus.res_carry}); end
        checks++; if ({bus.bk_a1, bus.bk_a2, bus.bk_wd} !== 12'h000) begin errors++; $display("FAIL rst_bank_drive: got %h required 000", {bus.bk_a1, bus.bk_a2, bus.bk_wd}); end
        bus.cmd_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b required 1", bus.cmd_ready); end
        checks++; if (bus.bk_we !== 1'b0) begin errors++; $display("FAIL rst_idle_we: got %b required 0", bus.bk_we); end
    endtask

    task automatic test_directed();
        run_cmd(3'd0, 2'd2, 2'd0, 2'd0, 8'h5A);
        run_cmd(3'd7, 2'd1, 2'd2, 2'd0, 8'h00);
        run_cmd(3'd0, 2'd0, 2'd0, 2'd0, 8'hF0);
        run_cmd(3'd0, 2'd1, 2'd0, 2'd0, 8'h20);
        run_cmd(3'd2, 2'd3, 2'd0, 2'd1, 8'h00);
        checks++; if (bank[3] !== 8'h10) begin errors++; $display("FAIL add_r3: got %h required 10", bank[3]); end
        run_cmd(3'd3, 2'd3, 2'd1, 2'd0, 8'h00);
        checks++; if (bank[3] !== 8'h30) begin errors++; $display("FAIL sub_r3: got %h required 30", bank[3]); end
        run_cmd(3'd6, 2'd0, 2'd0, 2'd0, 8'h00);
        checks++; if (bank[0] !== 8'h00) begin errors++; $display("FAIL xor_r0: got %h required 00", bank[0]); end
    endtask

    task automatic test_rd();
        logic [7:0] snap [4];
        for (int i = 0; i < 4; i++) snap[i] = bank[i];
        run_cmd(3'd7, 2'd0, 2'd3, 2'd1, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            checks++; if (bank[i] !== snap[i]) begin errors++; $display("FAIL rd_bank r%0d: got %h required %h", i, bank[i], snap[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops [3];
        logic [1:0] dsts [3], s1s [3], s2s [3];
        logic [7:0] imms [3];
        logic [7:0] expq [$];
        logic [9:0] e;
        int nacc, last, nres;
        bit adv;
        ops = '{3'd0, 3'd2, 3'd3}; dsts = '{2'd1, 2'd2, 2'd3};
        s1s = '{2'd0, 2'd1, 2'd2}; s2s = '{2'd0, 2'd1, 2'd0};
        imms = '{8'($urandom), 8'h00, 8'h00};
        nacc = 0; last = 0; nres = 0; adv = 0;
        @(negedge clk);
        drive_cmd(ops[0], dsts[0], s1s[0], s2s[0], imms[0]);
        bus.cmd_valid = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (adv) begin
                if (nacc < 3) drive_cmd(ops[nacc], dsts[nacc], s1s[nacc], s2s[nacc], imms[nacc]);
                else bus.cmd_valid = 1'b0;
                adv = 0;
            end
            if (bus.res_valid === 1'b1) begin
                checks++;
                if (expq.size() == 0) begin errors++; $display("FAIL b2b_extra_result: got %h required none", bus.res_data); end
                else begin
                    e[7:0] = expq.pop_front();
                    if (bus.res_data !== e[7:0]) begin errors++; $display("FAIL b2b_result%0d: got %h required %h", nres, bus.res_data, e[7:0]); end
                end
                nres++;
            end
            if (bus.cmd_valid && bus.cmd_ready === 1'b1) begin
                if (nacc > 0) begin
                    checks++; if (cyc - last != 4) begin errors++; $display("FAIL b2b_interval: got %0d required 4", cyc - last); end
                end
                last = cyc;
                e = ref_op(ops[nacc], mdl[s1s[nacc]], mdl[s2s[nacc]], imms[nacc]);
                mdl[dsts[nacc]] = e[7:0];
                expq.push_back(e[7:0]);
                nacc++;
                adv = 1;
            end
        end
        bus.cmd_valid = 1'b0;
        checks++; if (nacc != 3) begin errors++; $display("FAIL b2b_accepts: got %0d required 3", nacc); end
        checks++; if (nres != 3) begin errors++; $display("FAIL b2b_results: got %0d required 3", nres); end
        for (int i = 1; i < 4; i++) begin
            checks++; if (bank[i] !== mdl[i]) begin errors++; $display("FAIL b2b_bank r%0d: got %h required %h", i, bank[i], mdl[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int w;
        @(negedge clk);
        drive_cmd(3'd2, 2'd1, 2'd0, 2'd0, 8'h00);
        mdl[0] = bank[0];
        bus.cmd_valid = 1'b1;
        w = 0;
        while (!bus.cmd_ready && w < 20) begin @(negedge clk); w++; end
        @(posedge clk);
        @(negedge clk);          // FETCH
        bus.cmd_valid = 1'b0;
        @(negedge clk);          // EXEC
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) begin
                checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b required 1", bus.cmd_ready); end
                rst = 1'b0;
            end
            checks++; if (bus.bk_we !== 1'b0) begin errors++; $display("FAIL midrst_we%0d: got %b required 0", i, bus.bk_we); end
            checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL midrst_res_valid%0d: got %b required 0", i, bus.res_valid); end
        end
        checks++; if (bank[1] !== mdl[1]) begin errors++; $display("FAIL midrst_r1: got %h required %h", bank[1], mdl[1]); end
        run_cmd(3'd7, 2'd0, 2'd1, 2'd0, 8'h00);
    endtask

    task automatic test_reset_wb();
        logic [7:0] v;
        int w;
        v = 8'($urandom);
        @(negedge clk);
        drive_cmd(3'd0, 2'd2, 2'd0, 2'd0, v);
        bus.cmd_valid = 1'b1;
        w = 0;
        while (!bus.cmd_ready && w < 20) begin @(negedge clk); w++; end
        @(posedge clk);
        @(negedge clk);          // FETCH
        bus.cmd_valid = 1'b0;
        @(negedge clk);          // EXEC
        @(negedge clk);          // WB
        checks++; if (bus.bk_we !== 1'b1) begin errors++; $display("FAIL wbrst_we: got %b required 1", bus.bk_we); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mdl[2] = v;
        checks++; if (bank[2] !== v) begin errors++; $display("FAIL wbrst_write: got %h required %h", bank[2], v); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL wbrst_res_valid: got %b required 0", bus.res_valid); end
        @(negedge clk);
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL wbrst_res_valid2: got %b required 0", bus.res_valid); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++)
            run_cmd(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom));
        for (int i = 0; i < 4; i++) begin
            checks++; if (bank[i] !== mdl[i]) begin errors++; $display("FAIL rand_bank r%0d: got %h required %h", i, bank[i], mdl[i]); end
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        drive_cmd(3'd0, 2'd0, 2'd0, 2'd0, 8'h00);
        test_reset();
        test_directed();
        test_rd();
        test_back_to_back();
        test_reset_mid();
        test_reset_wb();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
